uart_lite_responder: RTL and testbench

AXI4-lite responder that presents a UART-Lite-compatible register map (RX FIFO, TX FIFO, STAT, CTRL) to the core's IO master. It buffers received bytes from a serial receiver and bytes destined for a serial transmitter in two byte FIFOs. It is the peripheral-side counterpart of the core's input and output polling state machines, and serves both as a synthesizable peripheral and as the simulation model behind the core's AXI port.

---
 rtl/uart_lite_responder_pkg.sv | 18 +
 rtl/uart_byte_fifo.sv | 42 ++++
 rtl/uart_lite_responder.sv | 122 ++++++++++++
 tb/tb_uart_lite_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_lite_responder_pkg.sv
// uart_lite_responder_pkg: register map, STAT/CTRL bit positions, response codes and FSM states
package uart_lite_responder_pkg;
  localparam logic [3:0] ADDR_RX = 4'h0;
  localparam logic [3:0] ADDR_TX = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'hC;
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL = 3;
  localparam int STAT_OVERRUN = 5;
  localparam int CTRL_TX_CLR = 0;
  localparam int CTRL_RX_CLR = 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH x 8 synchronous FIFO; clear beats push/pop, push into a full FIFO is accepted only alongside a pop
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_lite_responder.sv
// uart_lite_responder: AXI4-lite UART-Lite register map (RX, TX, STAT, CTRL) over two byte FIFOs
module uart_lite_responder
  import uart_lite_responder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic live, aw_done, w_done, overrun;
  logic [31:0] aw_addr_q, waddr, rdata_q, rd_val, stat;
  logic [7:0] w_data_q, wbyte, rx_head;
  logic [1:0] bresp_q, rresp_q, wsel, rsel;
  logic aw_hs, w_hs, ar_hs, exec, wbad, rbad, stat_rd, ov_set;
  logic rx_pop, rx_clr, rx_full, rx_empty, tx_push, tx_clr, tx_full, tx_empty;
  logic [CW-1:0] rx_count, tx_count;
  logic unused;
  assign unused = ^{axi_awprot, axi_arprot, axi_wstrb, axi_wdata[31:8], rx_count, tx_count};
  // live holds the readies low through reset and releases them on the first clock after
  assign axi_awready = live & (w_state == W_IDLE) & ~aw_done;
  assign axi_wready = live & (w_state == W_IDLE) & ~w_done;
  assign axi_arready = live & (r_state == R_IDLE);
  assign axi_bvalid = w_state == W_RESP;
  assign axi_bresp = bresp_q;
  assign axi_rvalid = r_state == R_RESP;
  assign axi_rdata = rdata_q;
  assign axi_rresp = rresp_q;
  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs = axi_wvalid & axi_wready;
  assign ar_hs = axi_arvalid & axi_arready;
  assign exec = (w_state == W_IDLE) & (aw_done | aw_hs) & (w_done | w_hs);
  assign waddr = aw_hs ? axi_awaddr : aw_addr_q;
  assign wbyte = w_hs ? axi_wdata[7:0] : w_data_q;
  assign wbad = |waddr[31:4];
  assign rbad = |axi_araddr[31:4];
  assign wsel = waddr[3:2];
  assign rsel = axi_araddr[3:2];
  assign tx_push = exec & ~wbad & (wsel == ADDR_TX[3:2]);
  assign tx_clr = exec & ~wbad & (wsel == ADDR_CTRL[3:2]) & wbyte[CTRL_TX_CLR];
  assign rx_clr = exec & ~wbad & (wsel == ADDR_CTRL[3:2]) & wbyte[CTRL_RX_CLR];
  assign rx_pop = ar_hs & ~rbad & (rsel == ADDR_RX[3:2]) & ~rx_empty;
  assign stat_rd = ar_hs & ~rbad & (rsel == ADDR_STAT[3:2]);
  // a byte lost to a CTRL clear is intentional, so it does not count as overrun
  assign ov_set = rx_valid & rx_full & ~rx_pop & ~rx_clr;
  assign tx_valid = ~tx_empty;
  always_comb begin
    stat = '0;
    stat[STAT_RX_VALID] = ~rx_empty;
    stat[STAT_RX_FULL] = rx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_TX_FULL] = tx_full;
    stat[STAT_OVERRUN] = overrun;
    rd_val = rbad ? 32'h0 :
             (rsel == ADDR_RX[3:2]) ? {24'h0, rx_head} :
             (rsel == ADDR_STAT[3:2]) ? stat : 32'h0;
    w_next = exec ? W_RESP : (w_state == W_RESP && axi_bready) ? W_IDLE : w_state;
    r_next = ar_hs ? R_RESP : (r_state == R_RESP && axi_rready) ? R_IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      live <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
      overrun <= 1'b0;
    end else begin
      live <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
      aw_done <= exec ? 1'b0 : aw_done | aw_hs;
      w_done <= exec ? 1'b0 : w_done | w_hs;
      if (aw_hs) aw_addr_q <= axi_awaddr;
      if (w_hs) w_data_q <= axi_wdata[7:0];
      if (exec) bresp_q <= wbad ? RESP_SLVERR : RESP_OKAY;
      if (ar_hs) begin
        rresp_q <= rbad ? RESP_SLVERR : RESP_OKAY;
        rdata_q <= rd_val;
      end
      overrun <= ov_set | (overrun & ~stat_rd);
    end
  uart_byte_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk(clk), .rstn(rstn), .push(rx_valid), .pop(rx_pop), .clr(rx_clr), .din(rx_data),
    .dout(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );
  uart_byte_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk(clk), .rstn(rstn), .push(tx_push), .pop(tx_ready), .clr(tx_clr), .din(wbyte),
    .dout(tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );
endmodule

// File: tb/tb_uart_lite_responder.sv
// tb_uart_lite_responder: directed AXI-lite register and FIFO checks with hand-computed expectations
module tb_uart_lite_responder;
  localparam int DEPTH = 16;
  logic clk = 0, rstn = 0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic rx_valid = 0, tx_valid, tx_ready = 0;
  logic [7:0] rx_data = 0, tx_data;
  logic [31:0] d;
  logic [1:0] r;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_lite_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awprot(3'b0),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arprot(3'b0),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] rd, output logic [1:0] rr);
    int n = 0;
    arvalid = 1;
    araddr = a;
    rready = 1;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    if (!arready) check("arready_timeout", 0, 1);
    tick();
    arvalid = 0;
    check("rvalid_lat", {31'b0, rvalid}, 1);
    rd = rdata;
    rr = rresp;
    tick();
    rready = 0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] wd, input int lead, output logic [1:0] br);
    awvalid = 1;
    awaddr = a;
    wstrb = 0;
    if (lead == 0) begin
      wvalid = 1;
      wdata = wd;
    end
    tick();
    awvalid = 0;
    if (lead > 0) begin
      check("awready_drop", {31'b0, awready}, 0);
      repeat (lead - 1) tick();
      wvalid = 1;
      wdata = wd;
      tick();
    end
    wvalid = 0;
    check("bvalid_lat", {31'b0, bvalid}, 1);
    br = bresp;
    bready = 1;
    tick();
    bready = 0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1;
    rx_data = b;
    tick();
    rx_valid = 0;
  endtask

  initial begin
    #2;
    check("rst_arready", {31'b0, arready}, 0);
    check("rst_awready", {31'b0, awready}, 0);
    check("rst_txvalid", {31'b0, tx_valid}, 0);
    check("rst_rdata", rdata, 0);
    tick();
    rstn = 1;
    tick();
    check("arready_up", {31'b0, arready}, 1);
    axi_read(32'h8, d, r);
    check("stat_reset", d, 32'h4);
    check("stat_reset_resp", {30'b0, r}, 0);

    axi_write(32'h4, 32'h41, 3, r);
    check("tx_bresp", {30'b0, r}, 0);
    check("tx_valid", {31'b0, tx_valid}, 1);
    check("tx_data", {24'b0, tx_data}, 32'h41);
    tx_ready = 1;
    tick();
    tx_ready = 0;
    check("tx_popped", {31'b0, tx_valid}, 0);

    rx_push(8'h55);
    rx_push(8'hAA);
    axi_read(32'h8, d, r);
    check("stat_rx2", d, 32'h5);
    axi_read(32'h0, d, r);
    check("rx_first", d, 32'h55);
    axi_read(32'h0, d, r);
    check("rx_second", d, 32'hAA);
    axi_read(32'h0, d, r);
    check("rx_empty_rd", d, 0);
    check("rx_empty_resp", {30'b0, r}, 0);
    axi_read(32'h8, d, r);
    check("stat_rx0", d, 32'h4);

    for (int i = 0; i <= DEPTH; i++) rx_push(8'(i));
    axi_read(32'h8, d, r);
    check("stat_overrun", d, 32'h27);
    axi_read(32'h8, d, r);
    check("stat_ov_clr", d, 32'h07);
    axi_read(32'h0, d, r);
    check("rx_head_kept", d, 32'h00);
    axi_write(32'hC, 32'h2, 0, r);
    axi_read(32'h8, d, r);
    check("stat_rx_clr", d, 32'h4);

    for (int i = 0; i < DEPTH; i++) axi_write(32'h4, 32'h10 + i, 0, r);
    axi_read(32'h8, d, r);
    check("stat_tx_full", d, 32'h08);
    axi_write(32'h4, 32'h99, 0, r);
    check("tx_full_bresp", {30'b0, r}, 0);
    check("tx_head_full", {24'b0, tx_data}, 32'h10);
    tx_ready = 1;
    axi_write(32'hC, 32'h1, 0, r);
    tx_ready = 0;
    check("tx_clr_valid", {31'b0, tx_valid}, 0);
    axi_read(32'h8, d, r);
    check("stat_tx_clr", d, 32'h4);

    rx_push(8'h33);
    axi_read(32'h10, d, r);
    check("bad_rresp", {30'b0, r}, 2);
    check("bad_rdata", d, 0);
    axi_write(32'h10, 32'h41, 0, r);
    check("bad_bresp", {30'b0, r}, 2);
    check("bad_no_tx", {31'b0, tx_valid}, 0);
    axi_read(32'h8, d, r);
    check("bad_stat", d, 32'h5);
    axi_read(32'h0, d, r);
    check("bad_rx_kept", d, 32'h33);

    arvalid = 1;
    araddr = 32'h8;
    rready = 0;
    tick();
    arvalid = 0;
    check("mid_rvalid", {31'b0, rvalid}, 1);
    #2 rstn = 0;
    #1 check("rst_rvalid_drop", {31'b0, rvalid}, 0);
    tick();
    rstn = 1;
    rready = 1;
    repeat (3) begin
      tick();
      check("no_resp_after_rst", {31'b0, rvalid}, 0);
    end
    check("arready_after_rst", {31'b0, arready}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
